// File: rtl/vdegen_if.sv
// Signal bundle between the video MCU mode/sync sources and the vertical timing generator.
// The master side drives mode selects and horizontal sync; the slave side returns the line count and decoded flags.
interface vdegen_if;
  logic       mde1;
  logic       ntsc;
  logic       ihsync;
  logic [8:0] vdec;
  logic       vsync;
  logic       vblank;
  logic       vde;
  logic       vfrm;

  modport master (
    output mde1, ntsc, ihsync,
    input  vdec, vsync, vblank, vde, vfrm
  );

  modport slave (
    input  mde1, ntsc, ihsync,
    output vdec, vsync, vblank, vde, vfrm
  );
endinterface

// File: rtl/vdegen.sv
// Vertical timing generator: counts scan lines on ihsync rising edges, wraps at the latched mode's
// frame length and decodes vsync / vblank / vde as registered flags aligned with the line count.
module vdegen #(
  parameter int PAL_LINES  = 313,
  parameter int NTSC_LINES = 263,
  parameter int MONO_LINES = 501
) (
  input logic     m2clock,
  input logic     porb,
  vdegen_if.slave bus
);

  typedef enum logic [1:0] {MODE_PAL, MODE_NTSC, MODE_MONO} mode_e;

  mode_e      mode_q, mode_d, mode_sel;
  logic       hs_q;
  logic [8:0] vdec_q, vdec_d, last_line;
  logic       line_stb, wrap;
  logic       vsync_q, vsync_d;
  logic       vblank_q, vblank_d;
  logic       vde_q, vde_d;
  logic       vfrm_q;

  function automatic logic in_win(input logic [8:0] v, input logic [8:0] lo, input logic [8:0] hi);
    return (v >= lo) && (v <= hi);
  endfunction

  // Mono overrides the ntsc select.
  always_comb begin
    mode_sel = MODE_PAL;
    if (bus.mde1)      mode_sel = MODE_MONO;
    else if (bus.ntsc) mode_sel = MODE_NTSC;
  end

  always_comb begin
    last_line = 9'(PAL_LINES - 1);
    case (mode_q)
      MODE_NTSC: last_line = 9'(NTSC_LINES - 1);
      MODE_MONO: last_line = 9'(MONO_LINES - 1);
      default:   last_line = 9'(PAL_LINES - 1);
    endcase
  end

  assign line_stb = bus.ihsync & ~hs_q;
  assign wrap     = line_stb && (vdec_q == last_line);

  // NOTE: every signal written here gets a default first so no path can leave it unassigned and infer a latch.
  always_comb begin
    mode_d = mode_q;
    vdec_d = vdec_q;
    if (line_stb) begin
      if (wrap) begin
        vdec_d = '0;
        mode_d = mode_sel;
      end else begin
        vdec_d = vdec_q + 9'd1;
      end
    end
  end

  // Flags decode the next count under the next mode, so they land on the same edge as vdec.
  always_comb begin
    vsync_d  = 1'b0;
    vblank_d = 1'b0;
    vde_d    = 1'b0;
    case (mode_d)
      MODE_NTSC: begin
        vsync_d  = in_win(vdec_d, 9'd260, 9'd262);
        vblank_d = in_win(vdec_d, 9'd16,  9'd257);
        vde_d    = in_win(vdec_d, 9'd34,  9'd233);
      end
      MODE_MONO: begin
        vsync_d  = in_win(vdec_d, 9'd497, 9'd500);
        vblank_d = in_win(vdec_d, 9'd0,   9'd496);
        vde_d    = in_win(vdec_d, 9'd34,  9'd433);
      end
      default: begin
        vsync_d  = in_win(vdec_d, 9'd310, 9'd312);
        vblank_d = in_win(vdec_d, 9'd25,  9'd307);
        vde_d    = in_win(vdec_d, 9'd63,  9'd262);
      end
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge m2clock) begin
    if (!porb) begin
      hs_q     <= 1'b0;
      vdec_q   <= '0;
      mode_q   <= mode_sel;
      vsync_q  <= 1'b0;
      vblank_q <= 1'b0;
      vde_q    <= 1'b0;
      vfrm_q   <= 1'b0;
    end else begin
      hs_q     <= bus.ihsync;
      vdec_q   <= vdec_d;
      mode_q   <= mode_d;
      vsync_q  <= vsync_d;
      vblank_q <= vblank_d;
      vde_q    <= vde_d;
      vfrm_q   <= wrap;
    end
  end

  assign bus.vdec   = vdec_q;
  assign bus.vsync  = vsync_q;
  assign bus.vblank = vblank_q;
  assign bus.vde    = vde_q;
  assign bus.vfrm   = vfrm_q;

endmodule

// File: tb/tb_vdegen.sv
// Self-checking bench for vdegen: a reference line/mode model pushes expected outputs into a
// scoreboard at each driven cycle; every scenario task pops and compares after the clock edge.
module tb_vdegen;

  typedef enum int {M_PAL, M_NTSC, M_MONO} tmode_e;

  typedef struct packed {
    logic [8:0] vdec;
    logic       vsync;
    logic       vblank;
    logic       vde;
    logic       vfrm;
  } obs_t;

  logic m2clock = 1'b0;
  logic porb    = 1'b1;

  vdegen_if bus ();

  vdegen dut (
    .m2clock (m2clock),
    .porb    (porb),
    .bus     (bus)
  );

  always #5 m2clock = ~m2clock;

  int     n_cmp = 0;
  int     n_err = 0;
  obs_t   sb[$];

  int     m_vdec;
  tmode_e m_mode;
  logic   m_hs;
  obs_t   m_out;

  function automatic obs_t obs();
    obs_t o;
    o.vdec   = bus.vdec;
    o.vsync  = bus.vsync;
    o.vblank = bus.vblank;
    o.vde    = bus.vde;
    o.vfrm   = bus.vfrm;
    return o;
  endfunction

  function automatic tmode_e sel_mode();
    if (bus.mde1) return M_MONO;
    if (bus.ntsc) return M_NTSC;
    return M_PAL;
  endfunction

  function automatic int frame_len(input tmode_e m);
    case (m)
      M_MONO:  return 501;
      M_NTSC:  return 263;
      default: return 313;
    endcase
  endfunction

  function automatic obs_t decode(input tmode_e m, input int v, input logic fr);
    obs_t o;
    int vs_lo, vs_hi, vb_lo, vb_hi, de_lo, de_hi;
    case (m)
      M_NTSC:  begin vs_lo = 260; vs_hi = 262; vb_lo = 16; vb_hi = 257; de_lo = 34; de_hi = 233; end
      M_MONO:  begin vs_lo = 497; vs_hi = 500; vb_lo = 0;  vb_hi = 496; de_lo = 34; de_hi = 433; end
      default: begin vs_lo = 310; vs_hi = 312; vb_lo = 25; vb_hi = 307; de_lo = 63; de_hi = 262; end
    endcase
    o.vdec   = 9'(v);
    o.vsync  = (v >= vs_lo) && (v <= vs_hi);
    o.vblank = (v >= vb_lo) && (v <= vb_hi);
    o.vde    = (v >= de_lo) && (v <= de_hi);
    o.vfrm   = fr;
    return o;
  endfunction

  // Call right after a falling edge; returns after the next falling edge with the expectation queued.
  task automatic drive(input logic ih);
    logic stb;
    bus.ihsync = ih;
    stb  = ih & ~m_hs;
    m_hs = ih;
    if (stb) begin
      if (m_vdec == frame_len(m_mode) - 1) begin
        m_vdec = 0;
        m_mode = sel_mode();
        m_out  = decode(m_mode, 0, 1'b1);
      end else begin
        m_vdec = m_vdec + 1;
        m_out  = decode(m_mode, m_vdec, 1'b0);
      end
    end else begin
      m_out.vfrm = 1'b0;
    end
    sb.push_back(m_out);
    @(negedge m2clock);
  endtask

  task automatic do_reset();
    porb       = 1'b0;
    bus.ihsync = 1'b0;
    m_hs   = 1'b0;
    m_vdec = 0;
    m_mode = sel_mode();
    m_out  = '0;
    sb.push_back(m_out);
    @(negedge m2clock);
    porb = 1'b1;
  endtask

  task automatic test_reset();
    obs_t exp, got;
    bus.mde1 = 1'b0; bus.ntsc = 1'b0;
    // A rising ihsync while reset is held must not count.
    porb = 1'b0; bus.ihsync = 1'b1;
    @(negedge m2clock);
    got = obs(); n_cmp++;
    if (got !== obs_t'(0)) begin
      n_err++; $display("FAIL reset_with_strobe: got vdec=%0d flags=%b expected vdec=0 flags=0000", got.vdec, got[3:0]);
    end
    do_reset();
    exp = sb.pop_front(); got = obs(); n_cmp++;
    if (got !== exp) begin
      n_err++; $display("FAIL reset_state: got vdec=%0d flags=%b expected vdec=%0d flags=%b", got.vdec, got[3:0], exp.vdec, exp[3:0]);
    end
  endtask

  task automatic test_pal();
    obs_t exp, got;
    int vde_cnt = 0, first_de = -1, frm_cnt = 0, wrap_at = -1;
    bus.mde1 = 1'b0; bus.ntsc = 1'b0;
    do_reset();
    exp = sb.pop_front(); got = obs(); n_cmp++;
    if (got !== exp) begin
      n_err++; $display("FAIL pal_reset: got vdec=%0d flags=%b expected vdec=%0d flags=%b", got.vdec, got[3:0], exp.vdec, exp[3:0]);
    end
    for (int i = 1; i <= 313; i++) begin
      drive(1'b1);
      exp = sb.pop_front(); got = obs(); n_cmp++;
      if (got !== exp) begin
        n_err++; $display("FAIL pal_strobe %0d: got vdec=%0d flags=%b expected vdec=%0d flags=%b", i, got.vdec, got[3:0], exp.vdec, exp[3:0]);
      end
      if (got.vde) begin
        vde_cnt++;
        if (first_de < 0) first_de = int'(got.vdec);
      end
      if (got.vfrm) begin frm_cnt++; wrap_at = i; end
      drive(1'b0);
      exp = sb.pop_front(); got = obs(); n_cmp++;
      if (got !== exp) begin
        n_err++; $display("FAIL pal_gap %0d: got vdec=%0d flags=%b expected vdec=%0d flags=%b", i, got.vdec, got[3:0], exp.vdec, exp[3:0]);
      end
      if (got.vfrm) frm_cnt++;
    end
    n_cmp++; if (vde_cnt !== 200) begin n_err++; $display("FAIL pal_vde_lines: got %0d expected 200", vde_cnt); end
    n_cmp++; if (first_de !== 63) begin n_err++; $display("FAIL pal_vde_start: got %0d expected 63", first_de); end
    n_cmp++; if (frm_cnt !== 1)   begin n_err++; $display("FAIL pal_vfrm_pulses: got %0d expected 1", frm_cnt); end
    n_cmp++; if (wrap_at !== 313) begin n_err++; $display("FAIL pal_wrap_strobe: got %0d expected 313", wrap_at); end
    n_cmp++; if (got.vdec !== 9'd0) begin n_err++; $display("FAIL pal_end_count: got %0d expected 0", got.vdec); end
  endtask

  task automatic test_ntsc();
    obs_t exp, got;
    logic prev_vb = 1'b0;
    int vs_cnt = 0, first_vs = -1, rise_at = -1, fall_at = -1, wrap_at = -1;
    bus.mde1 = 1'b0; bus.ntsc = 1'b1;
    do_reset();
    exp = sb.pop_front(); got = obs(); n_cmp++;
    if (got !== exp) begin
      n_err++; $display("FAIL ntsc_reset: got vdec=%0d flags=%b expected vdec=%0d flags=%b", got.vdec, got[3:0], exp.vdec, exp[3:0]);
    end
    for (int i = 1; i <= 263; i++) begin
      drive(1'b1);
      exp = sb.pop_front(); got = obs(); n_cmp++;
      if (got !== exp) begin
        n_err++; $display("FAIL ntsc_strobe %0d: got vdec=%0d flags=%b expected vdec=%0d flags=%b", i, got.vdec, got[3:0], exp.vdec, exp[3:0]);
      end
      if (got.vsync) begin
        vs_cnt++;
        if (first_vs < 0) first_vs = int'(got.vdec);
      end
      if (got.vblank && !prev_vb && rise_at < 0) rise_at = int'(got.vdec);
      if (!got.vblank && prev_vb && fall_at < 0) fall_at = int'(got.vdec);
      prev_vb = got.vblank;
      if (got.vfrm) wrap_at = i;
      drive(1'b0);
      exp = sb.pop_front(); got = obs(); n_cmp++;
      if (got !== exp) begin
        n_err++; $display("FAIL ntsc_gap %0d: got vdec=%0d flags=%b expected vdec=%0d flags=%b", i, got.vdec, got[3:0], exp.vdec, exp[3:0]);
      end
    end
    n_cmp++; if (vs_cnt !== 3)    begin n_err++; $display("FAIL ntsc_vsync_lines: got %0d expected 3", vs_cnt); end
    n_cmp++; if (first_vs !== 260) begin n_err++; $display("FAIL ntsc_vsync_start: got %0d expected 260", first_vs); end
    n_cmp++; if (rise_at !== 16)  begin n_err++; $display("FAIL ntsc_vblank_rise: got %0d expected 16", rise_at); end
    n_cmp++; if (fall_at !== 258) begin n_err++; $display("FAIL ntsc_vblank_fall: got %0d expected 258", fall_at); end
    n_cmp++; if (wrap_at !== 263) begin n_err++; $display("FAIL ntsc_wrap_strobe: got %0d expected 263", wrap_at); end
  endtask

  task automatic test_mono();
    obs_t exp, got;
    int vde_cnt = 0, first_de = -1, vb_low = 0, wrap_at = -1;
    bus.mde1 = 1'b1; bus.ntsc = 1'b1;
    do_reset();
    exp = sb.pop_front(); got = obs(); n_cmp++;
    if (got !== exp) begin
      n_err++; $display("FAIL mono_reset: got vdec=%0d flags=%b expected vdec=%0d flags=%b", got.vdec, got[3:0], exp.vdec, exp[3:0]);
    end
    for (int i = 1; i <= 501; i++) begin
      drive(1'b1);
      exp = sb.pop_front(); got = obs(); n_cmp++;
      if (got !== exp) begin
        n_err++; $display("FAIL mono_strobe %0d: got vdec=%0d flags=%b expected vdec=%0d flags=%b", i, got.vdec, got[3:0], exp.vdec, exp[3:0]);
      end
      if (got.vde) begin
        vde_cnt++;
        if (first_de < 0) first_de = int'(got.vdec);
      end
      if (!got.vblank) vb_low++;
      if (got.vfrm) wrap_at = i;
      drive(1'b0);
      exp = sb.pop_front(); got = obs(); n_cmp++;
      if (got !== exp) begin
        n_err++; $display("FAIL mono_gap %0d: got vdec=%0d flags=%b expected vdec=%0d flags=%b", i, got.vdec, got[3:0], exp.vdec, exp[3:0]);
      end
    end
    n_cmp++; if (vde_cnt !== 400) begin n_err++; $display("FAIL mono_vde_lines: got %0d expected 400", vde_cnt); end
    n_cmp++; if (first_de !== 34) begin n_err++; $display("FAIL mono_vde_start: got %0d expected 34", first_de); end
    n_cmp++; if (vb_low !== 4)    begin n_err++; $display("FAIL mono_vblank_low: got %0d expected 4", vb_low); end
    n_cmp++; if (wrap_at !== 501) begin n_err++; $display("FAIL mono_wrap_strobe: got %0d expected 501", wrap_at); end
  endtask

  task automatic test_mode_switch();
    obs_t exp, got;
    int wrap1 = -1, wrap2 = -1;
    bus.mde1 = 1'b0; bus.ntsc = 1'b0;
    do_reset();
    exp = sb.pop_front(); got = obs(); n_cmp++;
    if (got !== exp) begin
      n_err++; $display("FAIL switch_reset: got vdec=%0d flags=%b expected vdec=%0d flags=%b", got.vdec, got[3:0], exp.vdec, exp[3:0]);
    end
    for (int i = 1; i <= 313 + 263; i++) begin
      if (i == 101) bus.ntsc = 1'b1;
      drive(1'b1);
      exp = sb.pop_front(); got = obs(); n_cmp++;
      if (got !== exp) begin
        n_err++; $display("FAIL switch_strobe %0d: got vdec=%0d flags=%b expected vdec=%0d flags=%b", i, got.vdec, got[3:0], exp.vdec, exp[3:0]);
      end
      if (got.vfrm) begin
        if (wrap1 < 0) wrap1 = i;
        else if (wrap2 < 0) wrap2 = i;
      end
      drive(1'b0);
      exp = sb.pop_front(); got = obs(); n_cmp++;
      if (got !== exp) begin
        n_err++; $display("FAIL switch_gap %0d: got vdec=%0d flags=%b expected vdec=%0d flags=%b", i, got.vdec, got[3:0], exp.vdec, exp[3:0]);
      end
    end
    n_cmp++; if (wrap1 !== 313) begin n_err++; $display("FAIL switch_first_wrap: got %0d expected 313", wrap1); end
    n_cmp++; if (wrap2 !== 576) begin n_err++; $display("FAIL switch_second_wrap: got %0d expected 576", wrap2); end
  endtask

  task automatic test_hold();
    obs_t exp, got;
    logic [8:0] prev;
    int incs = 0;
    prev = bus.vdec;
    for (int r = 0; r < 3; r++) begin
      for (int c = 0; c < 100; c++) begin
        drive(c < 50 ? 1'b1 : 1'b0);
        exp = sb.pop_front(); got = obs(); n_cmp++;
        if (got !== exp) begin
          n_err++; $display("FAIL hold r%0d c%0d: got vdec=%0d flags=%b expected vdec=%0d flags=%b", r, c, got.vdec, got[3:0], exp.vdec, exp[3:0]);
        end
        if (got.vdec !== prev) incs++;
        prev = got.vdec;
      end
    end
    n_cmp++; if (incs !== 3) begin n_err++; $display("FAIL hold_increments: got %0d expected 3", incs); end
  endtask

  task automatic test_reset_mid();
    obs_t exp, got;
    bus.mde1 = 1'b0; bus.ntsc = 1'b0;
    do_reset();
    exp = sb.pop_front(); got = obs(); n_cmp++;
    if (got !== exp) begin
      n_err++; $display("FAIL mid_reset_start: got vdec=%0d flags=%b expected vdec=%0d flags=%b", got.vdec, got[3:0], exp.vdec, exp[3:0]);
    end
    for (int i = 1; i <= 200; i++) begin
      drive(1'b1);
      exp = sb.pop_front(); got = obs(); n_cmp++;
      if (got !== exp) begin
        n_err++; $display("FAIL mid_strobe %0d: got vdec=%0d flags=%b expected vdec=%0d flags=%b", i, got.vdec, got[3:0], exp.vdec, exp[3:0]);
      end
      drive(1'b0);
      exp = sb.pop_front(); got = obs(); n_cmp++;
      if (got !== exp) begin
        n_err++; $display("FAIL mid_gap %0d: got vdec=%0d flags=%b expected vdec=%0d flags=%b", i, got.vdec, got[3:0], exp.vdec, exp[3:0]);
      end
    end
    n_cmp++;
    if (got.vdec !== 9'd200 || got.vde !== 1'b1) begin
      n_err++; $display("FAIL mid_before_reset: got vdec=%0d vde=%b expected vdec=200 vde=1", got.vdec, got.vde);
    end
    do_reset();
    exp = sb.pop_front(); got = obs(); n_cmp++;
    if (got !== exp) begin
      n_err++; $display("FAIL mid_after_reset: got vdec=%0d flags=%b expected vdec=%0d flags=%b", got.vdec, got[3:0], exp.vdec, exp[3:0]);
    end
    drive(1'b1);
    exp = sb.pop_front(); got = obs(); n_cmp++;
    if (got !== exp) begin
      n_err++; $display("FAIL mid_first_strobe: got vdec=%0d flags=%b expected vdec=%0d flags=%b", got.vdec, got[3:0], exp.vdec, exp[3:0]);
    end
    n_cmp++; if (got.vdec !== 9'd1) begin n_err++; $display("FAIL mid_first_count: got %0d expected 1", got.vdec); end
    drive(1'b0);
    exp = sb.pop_front(); got = obs(); n_cmp++;
    if (got !== exp) begin
      n_err++; $display("FAIL mid_tail: got vdec=%0d flags=%b expected vdec=%0d flags=%b", got.vdec, got[3:0], exp.vdec, exp[3:0]);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    bus.mde1   = 1'b0;
    bus.ntsc   = 1'b0;
    bus.ihsync = 1'b0;
    @(negedge m2clock);
    test_reset();
    test_pal();
    test_ntsc();
    test_mono();
    test_mode_switch();
    test_hold();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/vdegen.md
Name: vdegen

Overview:
- Vertical timing generator for the video MCU.
- Counts scan lines from the horizontal sync pulse and wraps at the frame length for the latched video mode (PAL, NTSC or mono).
- Decodes the line count into vsync, vblank and vde.
- Sits directly upstream of the horizontal display-enable stage: that stage consumes vblank and vde and ANDs them with its own horizontal terms.

Parameters:
- PAL_LINES, 313, lines per frame in colour PAL mode.
- NTSC_LINES, 263, lines per frame in colour NTSC mode.
- MONO_LINES, 501, lines per frame in mono mode (mde1=1).

Ports:
- m2clock  in  1  system video clock; all state changes on rising edge.
- porb  in  1  reset.
- mde1  in  1  mono mode select; overrides ntsc.
- ntsc  in  1  1 = NTSC timing, 0 = PAL timing (colour modes only).
- ihsync  in  1  horizontal sync, active high, asynchronous-free (already synchronous to m2clock); one line = one rising edge.
- vdec  out  9  current line number.
- vsync  out  1  vertical sync, active high.
- vblank  out  1  1 = vertically visible, 0 = blanked (same polarity as the consumer's blank_n term).
- vde  out  1  vertical display enable, active high.
- vfrm  out  1  one-clock pulse on frame wrap.

Interface decision: one clock, m2clock; reset is porb, synchronous and active-low. The polarity and synchronicity are fixed.

Behaviour:
- Line strobe:
  - ihsync is registered into hs_d.
  - line_stb = ihsync & ~hs_d, i.e. the rising edge detected in the same cycle the high level is first sampled.
  - A held-high ihsync yields exactly one strobe.
- Mode latch:
  - mode_r ∈ {PAL, NTSC, MONO} is taken from mde1/ntsc on reset and on every wrap strobe only.
  - Mode changes mid-frame have no effect until the next wrap.
  - TOTAL = MONO_LINES if mono, else NTSC_LINES if ntsc, else PAL_LINES, all per mode_r.
- Counter (9 bits):
  - On line_stb: if vdec == TOTAL-1, vdec <= 0; else vdec <= vdec+1.
  - No strobe: hold.
  - vdec never exceeds TOTAL-1, because the mode is latched only at wrap.
- Decode:
  - All flags are registered and computed from the next-count value, so flags change in the same cycle as vdec (one clock after the strobe cycle).
  - Window inclusion [a..b] is inclusive.
  - PAL: vsync [310..312]; vblank=1 for [25..307]; vde [63..262] (200 lines).
  - NTSC: vsync [260..262]; vblank=1 for [16..257]; vde [34..233] (200 lines).
  - MONO: vsync [497..500]; vblank=1 for [0..496]; vde [34..433] (400 lines).
  - The wrap strobe's decode uses the new mode_r, since the mode is latched on that same edge.
- vfrm: 1 for exactly the cycle following a wrap strobe (registered alongside vdec=0); 0 otherwise.
- Reset (porb=0 at a rising edge):
  - vdec=0, hs_d=0, vsync=0, vblank=0, vde=0, vfrm=0; mode_r loaded.
  - Reset mid-frame aborts the frame immediately; the first strobe after release gives vdec=1.
- Simultaneous events:
  - Reset dominates a strobe.
  - A strobe in the reset-release cycle counts only if ihsync was low at the reset edge (hs_d=0 after reset).

Test Plan:
- Reset then PAL (mde1=0, ntsc=0), 313 ihsync pulses -> vdec 0→312→0; vfrm single pulse after the 313th strobe; vde high for exactly 200 lines starting at vdec=63.
- NTSC frame -> vsync high exactly at vdec 260, 261, 262; vblank rises at vdec=16 and falls at vdec=258; wrap after 263 strobes.
- Mono (mde1=1, ntsc=1) -> mono overrides ntsc; wrap at 501; vde high for vdec 34..433 (400 strobes); vblank low only for 497..500.
- Switch ntsc 0→1 at vdec=100 in PAL -> counting continues to 312 and wraps; the next frame wraps at 263.
- Hold ihsync high for 50 clocks, then low 50, repeated -> exactly one increment per high period; flags update one clock after the rising sample.
- Assert porb=0 for 1 cycle at vdec=200 during vde=1 -> next cycle vdec=0, vde=0, vblank=0, vsync=0; the following strobe gives vdec=1.
